// File: rtl/flash_addr_ctrl.sv
// Flash audio address walker: fetches 32-bit words forward or backward and
// plays them out as two 16-bit samples, one per audio tick, with restart handshake.
module flash_addr_ctrl #(
  parameter int unsigned       ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(23'h7FFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              direction,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  output logic [ADDR_W-1:0] flash_address,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              sample_valid,
  output logic              restart_done
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND, STEP, RESTART
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_reg;
  logic              dir_hold;
  logic              restart_armed;
  logic              restart_pend;

  logic [ADDR_W-1:0] step_addr_c;
  logic [ADDR_W-1:0] restart_addr_c;
  logic              restart_req_c;
  logic              play_tick_c;

  // Next word address with wrap at both ends of the clip
  always_comb begin
    step_addr_c = addr;
    if (direction) begin
      step_addr_c = (addr == MAX_ADDR) ? '0 : addr + ADDR_W'(1);
    end else begin
      step_addr_c = (addr == '0) ? MAX_ADDR : addr - ADDR_W'(1);
    end
  end

  assign restart_addr_c = direction ? '0 : MAX_ADDR;
  // A held restart only counts once; it must be seen low before it re-arms
  assign restart_req_c  = restart & restart_armed;
  assign play_tick_c    = sample_tick & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      data_reg      <= '0;
      dir_hold      <= 1'b0;
      restart_armed <= 1'b1;
      restart_pend  <= 1'b0;
      flash_read    <= 1'b0;
      flash_address <= '0;
      audio_sample  <= '0;
      sample_valid  <= 1'b0;
      restart_done  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      restart_done <= 1'b0;
      if (!restart) restart_armed <= 1'b1;

      case (state)
        IDLE: begin
          if (restart_req_c) begin
            state <= RESTART;
          end else if (start) begin
            state         <= REQ;
            flash_read    <= 1'b1;
            flash_address <= addr;
          end
        end

        REQ: begin
          if (restart_req_c) restart_pend <= 1'b1;
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            state      <= WAIT_DATA;
          end
        end

        // Bus transaction always completes; a pending restart discards the word
        WAIT_DATA: begin
          if (restart_req_c) restart_pend <= 1'b1;
          if (flash_readdatavalid) begin
            if (restart_pend || restart_req_c) begin
              state <= RESTART;
            end else begin
              data_reg <= flash_readdata;
              state    <= OUT_FIRST;
            end
          end
        end

        OUT_FIRST: begin
          if (restart_req_c) begin
            state <= RESTART;
          end else if (play_tick_c) begin
            dir_hold     <= direction;
            audio_sample <= direction ? data_reg[15:0] : data_reg[31:16];
            sample_valid <= 1'b1;
            state        <= OUT_SECOND;
          end
        end

        OUT_SECOND: begin
          if (restart_req_c) begin
            state <= RESTART;
          end else if (play_tick_c) begin
            audio_sample <= dir_hold ? data_reg[31:16] : data_reg[15:0];
            sample_valid <= 1'b1;
            state        <= STEP;
          end
        end

        STEP: begin
          if (restart_req_c) begin
            state <= RESTART;
          end else begin
            addr          <= step_addr_c;
            flash_address <= step_addr_c;
            flash_read    <= 1'b1;
            state         <= REQ;
          end
        end

        RESTART: begin
          addr          <= restart_addr_c;
          restart_done  <= 1'b1;
          restart_armed <= 1'b0;
          restart_pend  <= 1'b0;
          if (start) begin
            flash_read    <= 1'b1;
            flash_address <= restart_addr_c;
            state         <= REQ;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_addr_ctrl.sv
// Self-checking bench for flash_addr_ctrl: behavioural flash slave, sample
// scoreboard, table-driven word playback and hand-written restart/pause/reset cases.
module tb_flash_addr_ctrl;

  localparam int unsigned       ADDR_W   = 23;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              direction;
  logic              restart;
  logic              sample_tick;
  logic              flash_read;
  logic              flash_waitrequest;
  logic [ADDR_W-1:0] flash_address;
  logic [31:0]       flash_readdata;
  logic              flash_readdatavalid;
  logic [15:0]       audio_sample;
  logic              sample_valid;
  logic              restart_done;

  flash_addr_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .direction           (direction),
    .restart             (restart),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_address       (flash_address),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid),
    .restart_done        (restart_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              dir;
    logic [31:0]       word;
    logic [15:0]       s1;
    logic [15:0]       s2;
    logic [ADDR_W-1:0] next_addr;
  } vec_t;

  localparam int N_VEC = 6;
  vec_t vt [N_VEC];

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0]       samp_q [$];
  logic [ADDR_W-1:0] addr_exp_q [$];
  logic [31:0]       serve_word = '0;
  logic [31:0]       held_word  = '0;
  int ws        = 2;
  int wait_cnt  = 0;
  int resp_cnt  = 0;
  int acc_count = 0;
  int rd_count  = 0;
  int sv_count  = 0;
  int hi_run    = 0;
  int last_run  = 0;
  logic read_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  // Let the previous word's STEP pass before changing direction, then play both halves
  task automatic play(input vec_t v, input logic [31:0] nxt_word);
    cycles(2);
    direction = v.dir;
    cycles(10);
    samp_q.push_back(v.s1);
    tick();
    cycles(4);
    addr_exp_q.push_back(v.next_addr);
    serve_word = nxt_word;
    samp_q.push_back(v.s2);
    tick();
  endtask

  // Flash slave: ws wait cycles per request, data three cycles after acceptance
  initial begin
    flash_waitrequest   = 1'b1;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      if (!rst_n) begin
        resp_cnt = 0; wait_cnt = 0; flash_waitrequest = 1'b1;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata      = held_word;
          end
        end
        if (flash_read) begin
          if (wait_cnt < ws) begin
            flash_waitrequest = 1'b1;
            wait_cnt++;
          end else begin
            flash_waitrequest = 1'b0;
            wait_cnt = 0;
            if (addr_exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_req: address %h with nothing expected", flash_address);
            end else begin
              check("req_addr", 32'(flash_address), 32'(addr_exp_q.pop_front()));
            end
            held_word = serve_word;
            resp_cnt  = 3;
            acc_count++;
          end
        end else begin
          flash_waitrequest = 1'b1;
          wait_cnt = 0;
        end
      end
    end
  end

  // Output monitor: sample scoreboard, pulse counters, read-hold length
  initial begin
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        sv_count++;
        if (samp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_sample: got %h with nothing expected", audio_sample);
        end else begin
          check("sample", 32'(audio_sample), 32'(samp_q.pop_front()));
        end
      end
      if (restart_done) rd_count++;
      if (flash_read) begin
        read_seen = 1'b1;
        hi_run++;
      end else if (hi_run > 0) begin
        last_run = hi_run;
        hi_run   = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int rd0, sv0, acc0;

    rst_n = 1'b0; start = 1'b0; direction = 1'b1; restart = 1'b0; sample_tick = 1'b0;
    vt[0] = '{dir: 1'b1, word: 32'hAAAA5555, s1: 16'h5555, s2: 16'hAAAA, next_addr: 23'h1};
    vt[1] = '{dir: 1'b1, word: 32'hCAFEF00D, s1: 16'hF00D, s2: 16'hCAFE, next_addr: 23'h2};
    vt[2] = '{dir: 1'b0, word: 32'h13572468, s1: 16'h1357, s2: 16'h2468, next_addr: 23'h1};
    vt[3] = '{dir: 1'b0, word: 32'h0F0FF0F0, s1: 16'h0F0F, s2: 16'hF0F0, next_addr: 23'h0};
    vt[4] = '{dir: 1'b0, word: 32'h11112222, s1: 16'h1111, s2: 16'h2222, next_addr: MAX_ADDR};
    vt[5] = '{dir: 1'b1, word: 32'h89ABCDEF, s1: 16'hCDEF, s2: 16'h89AB, next_addr: 23'h0};

    cycles(3);
    check("rst_flash_read",    32'(flash_read),    32'd0);
    check("rst_flash_address", 32'(flash_address), 32'd0);
    check("rst_audio_sample",  32'(audio_sample),  32'd0);
    check("rst_sample_valid",  32'(sample_valid),  32'd0);
    check("rst_restart_done",  32'(restart_done),  32'd0);
    rst_n = 1'b1;
    cycles(4);
    check("idle_no_read", 32'(read_seen), 32'd0);

    // Forward/backward playback including backward wrap at 0 and forward wrap at MAX_ADDR
    serve_word = vt[0].word;
    addr_exp_q.push_back('0);
    start = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      play(vt[i], (i + 1 < N_VEC) ? vt[i + 1].word : 32'h0);
      if (i == 0) check("read_hold_cycles", 32'(last_run), 32'd3);
    end

    // Backward restart pulse while parked in OUT_FIRST
    cycles(12);
    rd0 = rd_count;
    direction = 1'b0;
    serve_word = 32'h12345678;
    addr_exp_q.push_back(MAX_ADDR);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    cycles(3);
    check("restart_done_pulse", 32'(rd_count - rd0), 32'd1);
    v = '{dir: 1'b0, word: 32'h12345678, s1: 16'h1234, s2: 16'h5678, next_addr: MAX_ADDR - 23'd1};
    play(v, 32'h55AA33CC);

    // Pause between halves
    cycles(12);
    samp_q.push_back(16'h55AA);
    tick();
    cycles(2);
    start = 1'b0;
    sv0 = sv_count;
    read_seen = 1'b0;
    repeat (5) begin
      tick();
      cycles(3);
    end
    check("pause_no_sample",   32'(sv_count - sv0), 32'd0);
    check("pause_hold_sample", 32'(audio_sample),   32'h55AA);
    check("pause_no_read",     32'(read_seen),      32'd0);
    start = 1'b1;
    addr_exp_q.push_back(MAX_ADDR - 23'd2);
    serve_word = 32'hDEADBEEF;
    samp_q.push_back(16'h33CC);
    tick();

    // Restart during the bus transaction, held high long after acknowledge
    acc0 = acc_count;
    for (int k = 0; k < 50 && acc_count == acc0; k++) @(negedge clk);
    check("deadbeef_accepted", 32'(acc_count != acc0), 32'd1);
    direction = 1'b1;
    rd0 = rd_count;
    sv0 = sv_count;
    serve_word = 32'hFACE0001;
    addr_exp_q.push_back('0);
    restart = 1'b1;
    cycles(40);
    restart = 1'b0;
    cycles(5);
    check("restart_held_once",  32'(rd_count - rd0), 32'd1);
    check("discard_no_sample",  32'(sv_count - sv0), 32'd0);
    check("discard_hold",       32'(audio_sample),   32'h33CC);

    // Play the restarted word, then reset while the next request is stalled
    cycles(12);
    samp_q.push_back(16'h0001);
    tick();
    cycles(4);
    ws = 20;
    samp_q.push_back(16'hFACE);
    tick();
    cycles(4);
    check("req_active",     32'(flash_read),    32'd1);
    check("req_addr_live",  32'(flash_address), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_read",   32'(flash_read),    32'd0);
    check("async_rst_addr",   32'(flash_address), 32'd0);
    check("async_rst_sample", 32'(audio_sample),  32'd0);
    start = 1'b0;
    ws = 2;
    cycles(2);
    rst_n = 1'b1;
    read_seen = 1'b0;
    cycles(4);
    check("post_rst_idle", 32'(read_seen), 32'd0);
    serve_word = 32'h600DCAFE;
    addr_exp_q.push_back('0);
    start = 1'b1;
    v = '{dir: 1'b1, word: 32'h600DCAFE, s1: 16'hCAFE, s2: 16'h600D, next_addr: 23'h1};
    play(v, 32'h0);

    cycles(20);
    check("samples_drained",  32'(samp_q.size()),     32'd0);
    check("requests_drained", 32'(addr_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
